sram_array: RTL
===============

Name: sram_array

Overview:
Parametrised single-port synchronous SRAM model; next generation of the 64x128 macro model used for cache data/tag arrays. Keeps the active-low chip-enable, write-enable and bit-mask conventions. Adds:
- configurable width, depth and read latency
- hardware clear-on-reset sequencer and a flush-triggered re-clear, with a ready handshake
- held read data with a valid strobe

It sits directly under the cache data/tag/valid array wrappers.

Parameters:
DATA_W, 128, data word width in bits (multiple of 8 when SRAM_PARITY_EN is defined)
DEPTH, 64, number of words (any value >= 2, need not be a power of two)
ADDR_W, $clog2(DEPTH), address width (derived; do not override)
RD_LAT, 1, read latency in cycles; legal values 1 or 2, anything else is an elaboration error

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
io_cen  input  1  active-low chip enable; a request exists when io_cen=0
io_wen  input  1  active-low write enable; 0=write, 1=read (qualified by io_cen=0)
io_addr  input  ADDR_W  word address
io_wmask  input  DATA_W  active-low bit mask; bit i is written when io_wmask[i]=0
io_wdata  input  DATA_W  write data
io_flush  input  1  active-high; starts a full re-clear of the array
io_ready  output  1  1 = array accepts requests this cycle
io_rdata  output  DATA_W  read data; held until the next read completes
io_rvalid  output  1  one-cycle strobe; io_rdata carries a new read result
io_perr  output  1  parity error flag, valid with io_rvalid (present only with SRAM_PARITY_EN)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=CLEAR, clear counter=0, io_ready=0, io_rdata=0, io_rvalid=0, io_perr=0.
  - All RD_LAT pipeline stages cleared.
  - Array contents are not reset directly; the sequencer clears them.
- States:
  - CLEAR: each cycle writes all-zero to word[counter], then counter+1. After writing word DEPTH-1 -> IDLE. io_ready=1 from the first cycle in IDLE. Clearing takes exactly DEPTH cycles after reset release.
  - IDLE: io_ready=1; services requests.
- Transitions:
  - IDLE + io_flush=1 -> CLEAR with counter=0. io_ready drops the next cycle. A request in the same cycle as io_flush is ignored.
  - io_flush=1 while in CLEAR restarts the counter at 0.
  - Reset asserted mid-clear or mid-read restarts everything; in-flight read results are discarded and no io_rvalid is issued.
- Request acceptance: only when io_ready=1 and io_cen=0; otherwise the request is ignored with no side effects.
- Write (io_wen=0):
  - word[addr] <= (io_wdata & ~io_wmask) | (word[addr] & io_wmask).
  - No io_rvalid; io_rdata unchanged.
- Read (io_wen=1), accepted in cycle N:
  - RD_LAT=1: io_rdata updated and io_rvalid=1 in cycle N+1.
  - RD_LAT=2: the same, in cycle N+2.
  - Pipelined: back-to-back reads are accepted every cycle with one result per cycle.
  - A write issued while reads are in flight does not alter read data already sampled (the read sees pre-write contents).
- Idle or write cycles: io_rdata holds its last value. This is a change from the old model, which zeroed its output.
- Out-of-range address (addr >= DEPTH):
  - A write is dropped.
  - A read returns all-zero with io_rvalid=1 and io_perr=0.

Optional Feature:
Macro SRAM_PARITY_EN.
- Defined:
  - The array stores DATA_W/8 extra even-parity bits, one per byte.
  - Parity is computed on the merged (post-mask) word at write time; the clear sequencer writes correct parity for zero.
  - On a read, io_perr=1 coincident with io_rvalid if any stored byte parity mismatches; io_perr=0 otherwise.
- Undefined:
  - No parity storage and no io_perr port.
  - All other behaviour is identical.

Test Plan:
- Defaults; release reset; hold io_cen=0 with reads -> io_ready=0 for exactly 64 cycles, then 1; no io_rvalid during the clear; the first accepted read of addr 5 returns 0.
- Write addr 3, data all-F, mask 0 -> then write addr 3, data 0, mask with upper 64 bits =1 -> read addr 3 returns 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000.
- RD_LAT=2: back-to-back reads of addrs 1,2,3 holding 0xA,0xB,0xC -> io_rvalid high in cycles N+2..N+4 carrying 0xA,0xB,0xC; io_rdata holds 0xC afterwards.
- After writing addr 10 = 0x55, pulse io_flush -> io_ready low for 64 cycles; a read of addr 10 afterwards returns 0. Asserting reset at clear cycle 20 -> on release, the full 64-cycle clear reruns.
- DEPTH=48: write addr 50 then read addr 50 -> rdata=0, io_rvalid=1, and no word in 0..47 is modified.
- SRAM_PARITY_EN: force one data bit of stored addr 7, then read addr 7 -> io_perr=1 with io_rvalid. A read of an unforced address -> io_perr=0.

Source files
------------

// File: rtl/sram_array.sv
// sram_array: parametrised single-port synchronous SRAM for the cache data,
// tag and valid arrays. Chip enable, write enable and bit mask are active-low.
// It has a clear-on-reset sequencer, a flush-triggered re-clear with an
// io_ready handshake, and a 1- or 2-cycle read pipeline. The last read result
// is held on io_rdata until the next read completes.
// Optional feature macro: SRAM_PARITY_EN stores one even-parity bit per data
// byte and adds the io_perr port.
module sram_array #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_cen,
   input  logic              io_wen,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_wmask,
   input  logic [DATA_W-1:0] io_wdata,
   input  logic              io_flush,
   output logic              io_ready,
   output logic [DATA_W-1:0] io_rdata,
`ifdef SRAM_PARITY_EN
   output logic              io_perr,
`endif
   output logic              io_rvalid
);

`ifdef SRAM_PARITY_EN
   localparam int PAR_W  = DATA_W / 8;
   localparam int WORD_W = DATA_W + PAR_W;
   localparam int RES_W  = DATA_W + 1;

   // Even parity per byte: the stored bit makes each byte plus parity XOR to 0.
   function automatic logic [PAR_W-1:0] byte_parity(input logic [DATA_W-1:0] d);
      logic [PAR_W-1:0] p;
      for (int b = 0; b < PAR_W; b++) begin
         p[b] = ^d[b*8 +: 8];
      end
      return p;
   endfunction
`else
   localparam int WORD_W = DATA_W;
   localparam int RES_W  = DATA_W;
`endif

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [WORD_W-1:0] mem_q [DEPTH];

   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [WORD_W-1:0] mem_wr_word;
   logic              addr_in_range;
   logic [WORD_W-1:0] rd_word;
   logic [DATA_W-1:0] merged;
   logic [WORD_W-1:0] wr_word;
   logic              rd_req;
   logic [RES_W-1:0]  rd_res;
   logic              fin_valid;
   logic [RES_W-1:0]  fin_res;
   logic              rvalid_q, rvalid_d;
   logic [RES_W-1:0]  res_q, res_d;

   // Out-of-range addresses read as zero (with good parity) and never write.
   assign addr_in_range = ({1'b0, io_addr} < (ADDR_W+1)'(DEPTH));
   assign rd_word       = addr_in_range ? mem_q[io_addr] : '0;
   assign merged        = (io_wdata & ~io_wmask) | (rd_word[DATA_W-1:0] & io_wmask);

`ifdef SRAM_PARITY_EN
   assign wr_word = {byte_parity(merged), merged};
   assign rd_res  = {(byte_parity(rd_word[DATA_W-1:0]) != rd_word[WORD_W-1:DATA_W]),
                     rd_word[DATA_W-1:0]};
`else
   assign wr_word = merged;
   assign rd_res  = rd_word;
`endif

   assign io_ready  = (state_q == ST_IDLE);
   assign io_rvalid = rvalid_q;
   assign io_rdata  = res_q[DATA_W-1:0];
`ifdef SRAM_PARITY_EN
   assign io_perr   = rvalid_q & res_q[DATA_W];
`endif

   // Next-state logic: clear sweep, flush restart and request decode onto the single write port.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_wr_en   = 1'b0;
      mem_wr_addr = io_addr;
      mem_wr_word = '0;
      rd_req      = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = cnt_q;
            if (io_flush) begin
               cnt_d = '0;
            end else if (cnt_q == LAST_ADDR) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         ST_IDLE: begin
            if (io_flush) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end else if (!io_cen) begin
               if (!io_wen) begin
                  mem_wr_en   = addr_in_range;
                  mem_wr_word = wr_word;
               end else begin
                  rd_req = 1'b1;
               end
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   // Sequencer state and clear counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Storage array; deliberately not reset, the sequencer zeroes it instead.
   always_ff @(posedge clock) begin
      if (mem_wr_en) begin
         mem_q[mem_wr_addr] <= mem_wr_word;
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic             s1_valid_q, s1_valid_d;
         logic [RES_W-1:0] s1_res_q, s1_res_d;

         // Extra stage holds the word sampled at acceptance, so later writes cannot change it.
         always_comb begin
            s1_valid_d = rd_req;
            s1_res_d   = rd_req ? rd_res : s1_res_q;
         end

         // Extra pipeline stage registers.
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               s1_valid_q <= 1'b0;
               s1_res_q   <= '0;
            end else begin
               s1_valid_q <= s1_valid_d;
               s1_res_q   <= s1_res_d;
            end
         end

         assign fin_valid = s1_valid_q;
         assign fin_res   = s1_res_q;
      end else if (RD_LAT == 1) begin : g_lat1
         assign fin_valid = rd_req;
         assign fin_res   = rd_res;
      end else begin : g_bad_lat
         $error("sram_array: RD_LAT must be 1 or 2");
         assign fin_valid = 1'b0;
         assign fin_res   = '0;
      end
   endgenerate

   // Output stage: strobe valid for one cycle, hold data until the next result.
   always_comb begin
      rvalid_d = fin_valid;
      res_d    = fin_valid ? fin_res : res_q;
   end

   // Output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rvalid_q <= 1'b0;
         res_q    <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         res_q    <= res_d;
      end
   end

endmodule
